// File: rtl/multi_word_fifo.sv
// multi_word_fifo
// Circular-buffer FIFO that accepts 0..BW_IN words and releases 0..BW_OUT
// words per cycle. The read side is first-word-fall-through: the head words
// are always presented on dat_out. Push and pop are all-or-nothing and are
// judged against the registered occupancy only, so a same-cycle pop never
// makes room and a same-cycle push never supplies data.
// Optional macro: MULTI_WORD_FIFO_STICKY_ERR_EN adds sticky ovf_err/unf_err.
// SIZE must be a power of two, >= 2 and >= max(BW_IN, BW_OUT).
module multi_word_fifo #(
  parameter int SIZE      = 16,
  parameter int BW_IN     = 2,
  parameter int BW_OUT    = 2,
  parameter int WIDTH     = 16,
  parameter int AF_THRESH = SIZE - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$clog2(BW_IN+1)-1:0]         push_cnt,
  input  logic [BW_IN-1:0][WIDTH-1:0]        dat_in,
  input  logic [$clog2(BW_OUT+1)-1:0]        pop_cnt,
  output logic [BW_OUT-1:0][WIDTH-1:0]       dat_out,
  output logic [$clog2(SIZE):0]              ocp,
  output logic                               is_full,
  output logic                               is_empty,
  output logic                               almost_full,
  output logic                               almost_empty,
`ifdef MULTI_WORD_FIFO_STICKY_ERR_EN
  output logic                               ovf_err,
  output logic                               unf_err,
`endif
  output logic                               push_rej,
  output logic                               pop_rej
);

  localparam int PW = $clog2(SIZE);
  localparam int OW = PW + 1;
  localparam int IW = $clog2(BW_IN + 1);
  localparam int QW = $clog2(BW_OUT + 1);

  // Storage is read combinationally at several head offsets at once, so it
  // maps to distributed RAM / registers rather than a registered-read block.
  logic [WIDTH-1:0] r_mem [SIZE];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [OW-1:0]    r_ocp;

  logic [IW-1:0]    w_push_cnt;
  logic [QW-1:0]    w_pop_cnt;
  logic [OW-1:0]    w_push_n;
  logic [OW-1:0]    w_pop_n;
  logic [OW-1:0]    w_room;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [OW-1:0]    w_ocp_next;

  // Clamp out-of-range request counts to the lane widths.
  always_comb begin
    w_push_cnt = push_cnt;
    w_pop_cnt  = pop_cnt;
    if (int'(push_cnt) > BW_IN) w_push_cnt = IW'(BW_IN);
    if (int'(pop_cnt) > BW_OUT) w_pop_cnt = QW'(BW_OUT);
  end

  assign w_push_n  = OW'(w_push_cnt);
  assign w_pop_n   = OW'(w_pop_cnt);
  assign w_room    = OW'(SIZE) - r_ocp;
  assign w_push_ok = (w_push_n <= w_room);
  assign w_pop_ok  = (w_pop_n <= r_ocp);
  assign push_rej  = (w_push_cnt != '0) & ~w_push_ok;
  assign pop_rej   = (w_pop_cnt != '0) & ~w_pop_ok;

  assign w_ocp_next = r_ocp + (w_push_ok ? w_push_n : '0)
                            - (w_pop_ok ? w_pop_n : '0);

  // Pointer and occupancy state; reset clears them and drops the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ocp    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(w_push_cnt);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(w_pop_cnt);
      r_ocp <= w_ocp_next;
    end
  end

  // Write accepted lanes; the index wraps naturally modulo SIZE.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BW_IN; i++) begin
      if (!rst && w_push_ok && (i < int'(w_push_cnt))) begin
        r_mem[r_wr_ptr + PW'(i)] <= dat_in[i];
      end
    end
  end

  // Head words fall through from storage; lanes past the occupancy read zero.
  for (genvar gi = 0; gi < BW_OUT; gi++) begin : g_out
    assign dat_out[gi] = (OW'(gi) < r_ocp) ? r_mem[r_rd_ptr + PW'(gi)] : '0;
  end

  assign ocp          = r_ocp;
  assign is_full      = (r_ocp == OW'(SIZE));
  assign is_empty     = (r_ocp == '0);
  assign almost_full  = (int'(r_ocp) >= AF_THRESH);
  assign almost_empty = (int'(r_ocp) <= AE_THRESH);

`ifdef MULTI_WORD_FIFO_STICKY_ERR_EN
  logic r_ovf_err;
  logic r_unf_err;

  // Sticky error capture of any rejected request, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      if (push_rej) r_ovf_err <= 1'b1;
      if (pop_rej)  r_unf_err <= 1'b1;
    end
  end

  assign ovf_err = r_ovf_err;
  assign unf_err = r_unf_err;
`endif

endmodule

// File: tb/tb_multi_word_fifo.sv
// Testbench for multi_word_fifo: a table of directed vectors, hand-written
// corner sequences (wrap straddle, underflow, mid-stream reset) and a random
// run, all checked against a queue-based model of the FIFO.
module tb_multi_word_fifo;

  localparam int SIZE   = 16;
  localparam int BW_IN  = 2;
  localparam int BW_OUT = 2;
  localparam int WIDTH  = 16;
  localparam int AF     = SIZE - 2;
  localparam int AE     = 2;

  logic                         clk;
  logic                         rst;
  logic [1:0]                   push_cnt;
  logic [BW_IN-1:0][WIDTH-1:0]  dat_in;
  logic [1:0]                   pop_cnt;
  logic [BW_OUT-1:0][WIDTH-1:0] dat_out;
  logic [4:0]                   ocp;
  logic                         is_full, is_empty, almost_full, almost_empty;
  logic                         push_rej, pop_rej;
`ifdef MULTI_WORD_FIFO_STICKY_ERR_EN
  logic                         ovf_err, unf_err;
`endif

  multi_word_fifo #(
    .SIZE(SIZE), .BW_IN(BW_IN), .BW_OUT(BW_OUT), .WIDTH(WIDTH),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .push_cnt(push_cnt), .dat_in(dat_in),
    .pop_cnt(pop_cnt), .dat_out(dat_out), .ocp(ocp),
    .is_full(is_full), .is_empty(is_empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef MULTI_WORD_FIFO_STICKY_ERR_EN
    .ovf_err(ovf_err), .unf_err(unf_err),
`endif
    .push_rej(push_rej), .pop_rej(pop_rej)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_step   = 0;

  // Reference model: contents as a queue, oldest word at index 0.
  logic [WIDTH-1:0] model_q[$];
  bit model_valid = 0;
  bit model_ovf   = 0;
  bit model_unf   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (step %0d)", name, act, exp, n_step);
    end
  endtask

  // Drive one cycle of requests, check the pre-edge view against the model,
  // clock it, and advance the model by the FIFO rules.
  task automatic step(input bit r, input int pc, input int pp,
                      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                      output bit prej, output bit qrej);
    int sz;
    bit pok, qok;
    assert (pc <= BW_IN && pp <= BW_OUT);
    rst      = r;
    push_cnt = 2'(pc);
    pop_cnt  = 2'(pp);
    dat_in   = {d1, d0};
    #1;
    sz   = model_q.size();
    pok  = (pc <= SIZE - sz);
    qok  = (pp <= sz);
    prej = push_rej;
    qrej = pop_rej;
    if (model_valid) begin
      check("ocp", 32'(ocp), 32'(sz));
      check("is_full", 32'(is_full), 32'(sz == SIZE));
      check("is_empty", 32'(is_empty), 32'(sz == 0));
      check("almost_full", 32'(almost_full), 32'(sz >= AF));
      check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
      check("dat_out0", 32'(dat_out[0]), 32'(sz > 0 ? model_q[0] : 16'h0));
      check("dat_out1", 32'(dat_out[1]), 32'(sz > 1 ? model_q[1] : 16'h0));
      check("push_rej", 32'(push_rej), 32'(pc != 0 && !pok));
      check("pop_rej", 32'(pop_rej), 32'(pp != 0 && !qok));
`ifdef MULTI_WORD_FIFO_STICKY_ERR_EN
      check("ovf_err", 32'(ovf_err), 32'(model_ovf));
      check("unf_err", 32'(unf_err), 32'(model_unf));
`endif
    end
    $display("step %0d rst=%0d push=%0d pop=%0d ocp=%0d out0=%h out1=%h prej=%0d qrej=%0d",
             n_step, r, pc, pp, ocp, dat_out[0], dat_out[1], push_rej, pop_rej);
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_valid = 1;
      model_ovf   = 0;
      model_unf   = 0;
    end else if (model_valid) begin
      if (pc != 0 && !pok) model_ovf = 1;
      if (pp != 0 && !qok) model_unf = 1;
      if (qok) repeat (pp) void'(model_q.pop_front());
      if (pok) for (int i = 0; i < pc; i++) model_q.push_back(i == 0 ? d0 : d1);
    end
    @(negedge clk);
    n_step++;
  endtask

  typedef struct {
    int               pc;
    int               pp;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    bit               e_prej;
    bit               e_qrej;
    int               e_ocp;
    logic [WIDTH-1:0] e_out0;
    bit               e_full;
    bit               e_af;
  } vec_t;

  localparam int NV = 12;
  vec_t vt[NV];

  initial begin
    bit prej, qrej;
    logic [WIDTH-1:0] X, Y, Z;
    rst = 1'b1; push_cnt = '0; pop_cnt = '0; dat_in = '0;
    @(negedge clk);

    step(1, 0, 0, 0, 0, prej, qrej);
    step(1, 0, 0, 0, 0, prej, qrej);

    // Reset state
    check("rst ocp", 32'(ocp), 0);
    check("rst is_empty", 32'(is_empty), 1);
    check("rst is_full", 32'(is_full), 0);
    check("rst almost_empty", 32'(almost_empty), 1);
    check("rst almost_full", 32'(almost_full), 0);
    check("rst dat_out", 32'(dat_out), 0);

    // Directed table: idle, fill to full with words 1..16, overflow,
    // full-with-simultaneous-pop-and-push, then a plain pop.
    vt[0] = '{0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0, 0};
    for (int k = 0; k < 8; k++)
      vt[1+k] = '{2, 0, 16'(2*k+1), 16'(2*k+2), 0, 0, 2*(k+1), 16'h1,
                  (2*(k+1) == 16), (2*(k+1) >= 14)};
    vt[9]  = '{1, 0, 16'h0099, 16'h0, 1, 0, 16, 16'h1, 1, 1};
    vt[10] = '{2, 2, 16'h0077, 16'h0078, 1, 0, 14, 16'h3, 0, 1};
    vt[11] = '{0, 2, 16'h0, 16'h0, 0, 0, 12, 16'h5, 0, 0};

    for (int i = 0; i < NV; i++) begin
      step(0, vt[i].pc, vt[i].pp, vt[i].d0, vt[i].d1, prej, qrej);
      check("tbl push_rej", 32'(prej), 32'(vt[i].e_prej));
      check("tbl pop_rej", 32'(qrej), 32'(vt[i].e_qrej));
      check("tbl ocp", 32'(ocp), 32'(vt[i].e_ocp));
      check("tbl dat_out0", 32'(dat_out[0]), 32'(vt[i].e_out0));
      check("tbl is_full", 32'(is_full), 32'(vt[i].e_full));
      check("tbl almost_full", 32'(almost_full), 32'(vt[i].e_af));
    end
    check("tbl dat_out1 after pops", 32'(dat_out[1]), 32'h6);
`ifdef MULTI_WORD_FIFO_STICKY_ERR_EN
    check("ovf_err after overflow", 32'(ovf_err), 1);
`endif

    // Wrap straddle: bring both pointers to 15 with the FIFO empty.
    step(1, 0, 0, 0, 0, prej, qrej);
    for (int k = 0; k < 7; k++) step(0, 2, 0, 16'(k), 16'(k + 100), prej, qrej);
    step(0, 1, 0, 16'h00ee, 0, prej, qrej);
    for (int k = 0; k < 7; k++) step(0, 0, 2, 0, 0, prej, qrej);
    step(0, 0, 1, 0, 0, prej, qrej);
    check("wrap pre ocp", 32'(ocp), 0);
    X = 16'hAAAA; Y = 16'h5555;
    step(0, 2, 0, X, Y, prej, qrej);
    check("wrap out0", 32'(dat_out[0]), 32'(X));
    check("wrap out1", 32'(dat_out[1]), 32'(Y));
    check("wrap ocp", 32'(ocp), 2);
    step(0, 0, 2, 0, 0, prej, qrej);
    check("wrap drained ocp", 32'(ocp), 0);
    check("wrap drained out", 32'(dat_out), 0);

    // Underflow with a single word present.
    Z = 16'h1234;
    step(0, 1, 0, Z, 16'hffff, prej, qrej);
    step(0, 0, 2, 0, 0, prej, qrej);
    check("unf pop_rej", 32'(qrej), 1);
    check("unf push_rej", 32'(prej), 0);
    check("unf ocp", 32'(ocp), 1);
    check("unf out0", 32'(dat_out[0]), 32'(Z));
    check("unf out1", 32'(dat_out[1]), 0);
`ifdef MULTI_WORD_FIFO_STICKY_ERR_EN
    check("unf_err set", 32'(unf_err), 1);
    step(0, 0, 0, 0, 0, prej, qrej);
    check("unf_err held", 32'(unf_err), 1);
`endif

    // Mid-stream reset with a push in the same cycle.
    for (int k = 0; k < 3; k++) step(0, 2, 0, 16'(16'h0300 + k), 16'(16'h0400 + k), prej, qrej);
    check("pre-rst ocp", 32'(ocp), 7);
    step(1, 2, 0, 16'hDEAD, 16'hBEEF, prej, qrej);
    check("mid rst ocp", 32'(ocp), 0);
    check("mid rst is_empty", 32'(is_empty), 1);
    check("mid rst dat_out", 32'(dat_out), 0);
`ifdef MULTI_WORD_FIFO_STICKY_ERR_EN
    check("mid rst ovf_err", 32'(ovf_err), 0);
    check("mid rst unf_err", 32'(unf_err), 0);
`endif
    step(0, 1, 0, 16'h4242, 16'h0, prej, qrej);
    check("post rst out0", 32'(dat_out[0]), 32'h4242);
    check("post rst out1", 32'(dat_out[1]), 0);

    // Random run with alternating fill/drain bias so both ends are reached.
    for (int n = 0; n < 600; n++) begin
      int pc, pp;
      bit r;
      r = ($urandom_range(0, 79) == 0);
      if ((n / 60) % 2 == 0) begin
        pc = $urandom_range(0, 2);
        pp = $urandom_range(0, 1);
      end else begin
        pc = $urandom_range(0, 1);
        pp = $urandom_range(0, 2);
      end
      step(r, pc, pp, 16'($urandom), 16'($urandom), prej, qrej);
    end
    step(0, 0, 0, 0, 0, prej, qrej);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_word_fifo.md
Name: multi_word_fifo

Overview:
- Next-generation FIFO for the systolic-array datapath, storing `word_t` entries in a circular buffer of SIZE words.
- Each cycle it accepts a variable count of 0..BW_IN words and releases a variable count of 0..BW_OUT words.
- Read side is first-word-fall-through: the head words are always visible without a pop.
- Adds programmable almost-full/almost-empty thresholds and explicit reject strobes. It replaces the single-count push/pop FIFO between the input streamers and the PE array edges.

Parameters:
- SIZE, 16, depth in words; must be a power of 2 and >= max(BW_IN, BW_OUT).
- BW_IN, 2, maximum words pushed per cycle.
- BW_OUT, 2, maximum words popped/visible per cycle.
- AF_THRESH, SIZE-2, almost_full asserts when ocp >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when ocp <= AE_THRESH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- push_cnt  in  $clog2(BW_IN+1)  words to push this cycle; 0 = no push.
- dat_in  in  word_t[BW_IN-1:0]  push data; dat_in[0] is oldest; lanes >= push_cnt are ignored.
- pop_cnt  in  $clog2(BW_OUT+1)  words to pop this cycle; 0 = no pop.
- dat_out  out  word_t[BW_OUT-1:0]  head words; dat_out[0] is the oldest word.
- ocp  out  $clog2(SIZE)+1  current occupancy in words.
- is_full  out  1  ocp == SIZE.
- is_empty  out  1  ocp == 0.
- almost_full  out  1  ocp >= AF_THRESH.
- almost_empty  out  1  ocp <= AE_THRESH.
- push_rej  out  1  combinational; the current push request is rejected.
- pop_rej  out  1  combinational; the current pop request is rejected.

Behaviour:
- State: storage array mem[SIZE], wr_ptr and rd_ptr ($clog2(SIZE) bits, wrap modulo SIZE), and the ocp register.
- Reset (rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, ocp=0. After reset: is_empty=1, is_full=0, almost_empty=1, almost_full=(AF_THRESH==0), dat_out all zero. Memory contents are not cleared.
- Push acceptance is all-or-nothing and evaluated on registered state only:
  - push_ok = push_cnt <= SIZE-ocp.
  - A same-cycle pop does not create room.
  - push_rej = (push_cnt != 0) & ~push_ok.
- Pop acceptance is all-or-nothing:
  - pop_ok = pop_cnt <= ocp.
  - A same-cycle push does not supply data; no bypass path.
  - pop_rej = (pop_cnt != 0) & ~pop_ok.
- On an accepted push, at the clock edge:
  - mem[(wr_ptr+i) mod SIZE] <= dat_in[i] for i < push_cnt.
  - wr_ptr <= wr_ptr + push_cnt.
- On an accepted pop, at the clock edge: rd_ptr <= rd_ptr + pop_cnt.
- ocp update: ocp <= ocp + (push_ok ? push_cnt : 0) - (pop_ok ? pop_cnt : 0). Accepted push and pop in the same cycle are both applied.
- Pointer wrap: all pointer arithmetic is modulo SIZE; a multi-word push or pop may straddle the wrap point.
- dat_out[i]:
  - equals mem[(rd_ptr+i) mod SIZE] when i < ocp, else 0;
  - is a combinational function of registered state (first-word-fall-through);
  - zero latency from state, so a word pushed at edge N is visible at dat_out[0] after edge N if the FIFO was empty.
- Status flags are decoded from the registered ocp; no combinational path from push_cnt or pop_cnt.
- push_cnt > BW_IN or pop_cnt > BW_OUT is illegal; the bench asserts against it, and the RTL clamps the value to BW_IN/BW_OUT.
- rst asserted mid-stream: pointers and ocp clear on that edge. Push and pop in the same cycle are discarded.

Optional Feature:
- Macro: MULTI_WORD_FIFO_STICKY_ERR_EN.
- Defined: adds output ports ovf_err and unf_err (1 bit each).
  - ovf_err sets on any cycle with push_rej=1; unf_err sets on any cycle with pop_rej=1.
  - Both hold until rst and reset to 0.
- Undefined: these ports and their registers are absent; push_rej/pop_rej remain as the only error indication.

Test Plan:
1. Reset then idle, SIZE=16: ocp=0, is_empty=1, almost_empty=1, dat_out={0,0}, push_rej=0, pop_rej=0.
2. Push_cnt=2 with {A,B} for 8 cycles: after the 8th edge ocp=16 and is_full=1; almost_full first asserts when ocp reaches 14. A further push_cnt=1 gives push_rej=1 and ocp stays 16.
3. From full, issue pop_cnt=2 and push_cnt=2 in the same cycle:
   - push_rej=1, because there is no room credit from the same-cycle pop;
   - pop is accepted, ocp=14, dat_out shows words 3 and 4.
4. Wrap straddle: reach wr_ptr=15 and rd_ptr=15 with ocp=0, then push {X,Y}:
   - X is stored at index 15 and Y at index 0;
   - next cycle dat_out={X,Y};
   - pop_cnt=2 gives ocp=0, rd_ptr=1.
5. With ocp=1 (word Z), pop_cnt=2: pop_rej=1, ocp stays 1, dat_out={Z,0}. With the macro defined, unf_err=1 from the next edge until rst.
6. Assert rst while ocp=7 and push_cnt=2 in the same cycle: next cycle ocp=0, is_empty=1, no write is visible, and sticky error flags are cleared.
